// File: rtl/sockit_spi_ser.sv
// SPI serializer: turns queue-protocol packets into SPI pin activity on 1/2/4 lanes
// and returns the captured input bits as queue-protocol words.
module sockit_spi_ser #(
  parameter int unsigned SDW = 8,
  parameter int unsigned SDL = $clog2(SDW),
  parameter int unsigned QCO = SDL + 7,
  parameter int unsigned QDW = 4 * SDW,
  parameter int unsigned DVW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DVW-1:0] cfg_div,
  input  logic           cfg_cpol,
  input  logic           que_vld,
  input  logic [QCO-1:0] que_ctl,
  input  logic [QDW-1:0] que_dat,
  output logic           que_rdy,
  output logic           qin_vld,
  output logic [SDL+2:0] qin_ctl,
  output logic [QDW-1:0] qin_dat,
  input  logic           qin_rdy,
  output logic           spi_sclk,
  output logic           spi_ss_n,
  output logic [3:0]     spi_sio_o,
  output logic [3:0]     spi_sio_e,
  input  logic [3:0]     spi_sio_i
);

  typedef enum logic [1:0] {StIdl, StPh0, StPh1} state_e;

  // Lanes taking part in the transfer for a given IO mode.
  function automatic logic [3:0] lane_mask(input logic [1:0] iom);
    case (iom)
      2'd2:    return 4'b0011;
      2'd3:    return 4'b1111;
      default: return 4'b0001;
    endcase
  endfunction

  // MSB of each active lane; inactive lanes idle high.
  function automatic logic [3:0] first_bits(input logic [QDW-1:0] dat, input logic [1:0] iom);
    logic [3:0] m;
    logic [3:0] o;
    m = lane_mask(iom);
    for (int k = 0; k < 4; k++) o[k] = m[k] ? dat[k*SDW + SDW - 1] : 1'b1;
    return o;
  endfunction

  function automatic logic [QDW-1:0] shift_out(input logic [QDW-1:0] dat);
    logic [QDW-1:0] r;
    for (int k = 0; k < 4; k++) r[k*SDW +: SDW] = {dat[k*SDW +: SDW-1], 1'b0};
    return r;
  endfunction

  // Standard SPI reads MISO on sio_i[1]; every other mode reads lane k from sio_i[k].
  function automatic logic [QDW-1:0] shift_in(input logic [QDW-1:0] dat, input logic [3:0] sio,
                                              input logic [1:0] iom);
    logic [3:0]     b;
    logic [QDW-1:0] r;
    case (iom)
      2'd0:    b = {3'b000, sio[0]};
      2'd1:    b = {3'b000, sio[1]};
      2'd2:    b = {2'b00, sio[1:0]};
      default: b = sio;
    endcase
    for (int k = 0; k < 4; k++) r[k*SDW +: SDW] = {dat[k*SDW +: SDW-1], b[k]};
    return r;
  endfunction

  state_e         state_q, state_d;
  logic [DVW-1:0] div_q, div_d, cnt_q, cnt_d;
  logic           cpol_q, cpol_d;
  logic [SDL-1:0] bcnt_q, bcnt_d, len_q, len_d;
  logic           lst_q, lst_d, die_q, die_d, cke_q, cke_d;
  logic [1:0]     iom_q, iom_d;
  logic [QDW-1:0] sdo_q, sdo_d, sdi_q, sdi_d, sdo_sh;
  logic           sclk_q, sclk_d, ss_n_q, ss_n_d;
  logic [3:0]     sio_o_q, sio_o_d, sio_e_q, sio_e_d;
  logic           qin_vld_q, qin_vld_d;
  logic [SDL+2:0] qin_ctl_q, qin_ctl_d;
  logic [QDW-1:0] qin_dat_q, qin_dat_d;
  logic           que_trn, qin_trn, phase_end, done;

  assign que_rdy   = (state_q == StIdl) & ~qin_vld_q;
  assign que_trn   = que_vld & que_rdy;
  assign qin_trn   = qin_vld_q & qin_rdy;
  assign phase_end = (cnt_q == div_q);

  // Idle SCLK follows the live polarity setting so reset shows the idle level directly.
  assign spi_sclk  = (state_q == StIdl) ? cfg_cpol : sclk_q;
  assign spi_ss_n  = ss_n_q;
  assign spi_sio_o = sio_o_q;
  assign spi_sio_e = sio_e_q;
  assign qin_vld   = qin_vld_q;
  assign qin_ctl   = qin_ctl_q;
  assign qin_dat   = qin_dat_q;

  // Next-state: packet load, phase timing, bit shifting and captured-word handoff.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    cpol_d    = cpol_q;
    bcnt_d    = bcnt_q;
    len_d     = len_q;
    lst_d     = lst_q;
    iom_d     = iom_q;
    die_d     = die_q;
    cke_d     = cke_q;
    sdo_d     = sdo_q;
    sdi_d     = sdi_q;
    sclk_d    = sclk_q;
    ss_n_d    = ss_n_q;
    sio_o_d   = sio_o_q;
    sio_e_d   = sio_e_q;
    qin_vld_d = qin_vld_q;
    qin_ctl_d = qin_ctl_q;
    qin_dat_d = qin_dat_q;
    done      = 1'b0;
    sdo_sh    = shift_out(sdo_q);

    unique case (state_q)
      StIdl: begin
        if (que_trn) begin
          state_d = StPh0;
          div_d   = cfg_div;
          cpol_d  = cfg_cpol;
          cnt_d   = '0;
          bcnt_d  = que_ctl[SDL+6:7];
          len_d   = que_ctl[SDL+6:7];
          lst_d   = que_ctl[6];
          iom_d   = que_ctl[5:4];
          die_d   = que_ctl[3];
          cke_d   = que_ctl[0];
          sdo_d   = que_dat;
          sdi_d   = '0;
          ss_n_d  = ~que_ctl[1];
          sclk_d  = cfg_cpol;
          sio_e_d = que_ctl[2] ? lane_mask(que_ctl[5:4]) : 4'b0000;
          sio_o_d = first_bits(que_dat, que_ctl[5:4]);
        end
      end
      StPh0: begin
        if (phase_end) begin
          cnt_d   = '0;
          state_d = StPh1;
          if (cke_q) sclk_d = ~cpol_q;
          sdi_d   = shift_in(sdi_q, spi_sio_i, iom_q);
        end else begin
          cnt_d = cnt_q + DVW'(1);
        end
      end
      StPh1: begin
        if (phase_end) begin
          cnt_d  = '0;
          sclk_d = cpol_q;
          if (bcnt_q == '0) begin
            state_d = StIdl;
            sio_e_d = 4'b0000;
            done    = 1'b1;
          end else begin
            state_d = StPh0;
            bcnt_d  = bcnt_q - SDL'(1);
            sdo_d   = sdo_sh;
            sio_o_d = first_bits(sdo_sh, iom_q);
          end
        end else begin
          cnt_d = cnt_q + DVW'(1);
        end
      end
      default: state_d = StIdl;
    endcase

    // A freshly completed word takes priority over the consumer draining the old one.
    if (done && die_q) begin
      qin_vld_d = 1'b1;
      qin_ctl_d = {len_q, lst_q, iom_q};
      qin_dat_d = sdi_q;
    end else if (qin_trn) begin
      qin_vld_d = 1'b0;
    end
  end

  // State registers; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdl;
      div_q     <= '0;
      cnt_q     <= '0;
      cpol_q    <= 1'b0;
      bcnt_q    <= '0;
      len_q     <= '0;
      lst_q     <= 1'b0;
      iom_q     <= 2'd0;
      die_q     <= 1'b0;
      cke_q     <= 1'b0;
      sdo_q     <= '0;
      sdi_q     <= '0;
      sclk_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      sio_o_q   <= 4'hF;
      sio_e_q   <= 4'h0;
      qin_vld_q <= 1'b0;
      qin_ctl_q <= '0;
      qin_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      cpol_q    <= cpol_d;
      bcnt_q    <= bcnt_d;
      len_q     <= len_d;
      lst_q     <= lst_d;
      iom_q     <= iom_d;
      die_q     <= die_d;
      cke_q     <= cke_d;
      sdo_q     <= sdo_d;
      sdi_q     <= sdi_d;
      sclk_q    <= sclk_d;
      ss_n_q    <= ss_n_d;
      sio_o_q   <= sio_o_d;
      sio_e_q   <= sio_e_d;
      qin_vld_q <= qin_vld_d;
      qin_ctl_q <= qin_ctl_d;
      qin_dat_q <= qin_dat_d;
    end
  end

endmodule

// File: tb/tb_sockit_spi_ser.sv
// Self-checking bench for sockit_spi_ser: directed pin-level checks plus a scoreboard
// of expected captured words compared whenever the DUT hands one over.
module tb_sockit_spi_ser;

  logic        clk;
  logic        rst;
  logic [7:0]  cfg_div;
  logic        cfg_cpol;
  logic        que_vld;
  logic [9:0]  que_ctl;
  logic [31:0] que_dat;
  logic        que_rdy;
  logic        qin_vld;
  logic [5:0]  qin_ctl;
  logic [31:0] qin_dat;
  logic        qin_rdy;
  logic        spi_sclk;
  logic        spi_ss_n;
  logic [3:0]  spi_sio_o;
  logic [3:0]  spi_sio_e;
  logic [3:0]  spi_sio_i;

  // 0: external pattern, 1: MISO looped from lane0, 2: every lane looped back
  logic [1:0]  lb_mode;
  logic [3:0]  ext_sio;

  int n_checks = 0;
  int n_errors = 0;

  logic [37:0] sb_q[$];
  logic [37:0] exp_w;

  assign spi_sio_i = (lb_mode == 2'd1) ? {2'b00, spi_sio_o[0], 1'b0} :
                     (lb_mode == 2'd2) ? spi_sio_o : ext_sio;

  sockit_spi_ser dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_div   (cfg_div),
    .cfg_cpol  (cfg_cpol),
    .que_vld   (que_vld),
    .que_ctl   (que_ctl),
    .que_dat   (que_dat),
    .que_rdy   (que_rdy),
    .qin_vld   (qin_vld),
    .qin_ctl   (qin_ctl),
    .qin_dat   (qin_dat),
    .qin_rdy   (qin_rdy),
    .spi_sclk  (spi_sclk),
    .spi_ss_n  (spi_ss_n),
    .spi_sio_o (spi_sio_o),
    .spi_sio_e (spi_sio_e),
    .spi_sio_i (spi_sio_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] mk_ctl(input logic [2:0] len, input logic lst,
                                        input logic [1:0] iom, input logic die,
                                        input logic doe, input logic sso, input logic cke);
    return {len, lst, iom, die, doe, sso, cke};
  endfunction

  // Loopback makes each active input lane see its own output bits, MSB first.
  function automatic logic [31:0] cap_model(input logic [1:0] iom, input logic [2:0] len,
                                            input logic [31:0] dat);
    logic [31:0] r;
    logic [7:0]  lane;
    int          n;
    n = (iom == 2'd3) ? 4 : (iom == 2'd2) ? 2 : 1;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < n) begin
        lane = dat[k*8 +: 8];
        r[k*8 +: 8] = lane >> (7 - int'(len));
      end
    end
    return r;
  endfunction

  task automatic push_exp(input logic [9:0] ctl, input logic [31:0] dat);
    sb_q.push_back({ctl[9:4], cap_model(ctl[5:4], ctl[9:7], dat)});
  endtask

  // Returns just after the accepting clock edge.
  task automatic send(input logic [9:0] ctl, input logic [31:0] dat);
    @(negedge clk);
    que_ctl = ctl;
    que_dat = dat;
    que_vld = 1'b1;
    for (int w = 0; w < 500 && !que_rdy; w++) @(negedge clk);
    check("que_rdy_wait", que_rdy, 1);
    @(posedge clk);
    #1;
    que_vld = 1'b0;
  endtask

  task automatic wait_idle();
    for (int w = 0; w < 500; w++) begin
      @(negedge clk);
      if (que_rdy) break;
    end
    check("idle_wait", que_rdy, 1);
  endtask

  // Scoreboard consumer: a transfer completes on the next edge when both are high.
  always @(negedge clk) begin
    if (rst && qin_vld && qin_rdy) begin
      if (sb_q.size() == 0) begin
        check("qin_unexpected", 0, 1);
      end else begin
        exp_w = sb_q.pop_front();
        check("qin_word", {qin_ctl, qin_dat}, exp_w);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [9:0]  ctl;
    logic [9:0]  ctl2;
    logic [31:0] dat;
    logic [31:0] dat2;
    logic [7:0]  mosi;
    logic [3:0]  sclk_seq;
    logic [1:0]  iom;
    logic [2:0]  len;
    int          pulses;
    int          bad;
    int          bad_ss;
    int          bad_mosi;

    rst      = 1'b0;
    que_vld  = 1'b0;
    que_ctl  = '0;
    que_dat  = '0;
    qin_rdy  = 1'b1;
    cfg_div  = 8'd0;
    cfg_cpol = 1'b1;
    lb_mode  = 2'd0;
    ext_sio  = 4'h0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_sclk_cpol1", spi_sclk, 1);
    cfg_cpol = 1'b0;
    #1;
    check("rst_sclk_cpol0", spi_sclk, 0);
    check("rst_ss_n", spi_ss_n, 1);
    check("rst_sio_e", spi_sio_e, 4'h0);
    check("rst_sio_o", spi_sio_o, 4'hF);
    check("rst_qin_vld", qin_vld, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("que_rdy_after_rst", que_rdy, 1);

    // Standard SPI, MISO looped to MOSI
    cfg_div  = 8'd0;
    cfg_cpol = 1'b0;
    lb_mode  = 2'd1;
    ctl = mk_ctl(3'd7, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    dat = 32'h0000_00A5;
    push_exp(ctl, dat);
    send(ctl, dat);
    pulses = 0;
    bad    = 0;
    mosi   = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("spi_ss_n_start", spi_ss_n, 0);
        check("spi_sio_e", spi_sio_e, 4'b0001);
      end
      if (i % 2 == 0) begin
        mosi = {mosi[6:0], spi_sio_o[0]};
        if (spi_sclk !== 1'b0) bad++;
      end else if (spi_sclk === 1'b1) begin
        pulses++;
      end
    end
    check("spi_pulses", pulses, 8);
    check("spi_sclk_ph0_low", bad, 0);
    check("spi_mosi", mosi, 8'hA5);
    @(negedge clk);
    check("spi_done_vld", qin_vld, 1);
    check("spi_done_sio_e", spi_sio_e, 4'h0);
    check("spi_idle_sclk", spi_sclk, 0);
    wait_idle();

    // Quad output, no capture
    lb_mode = 2'd0;
    ctl = mk_ctl(3'd1, 1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    dat = 32'h8000_8040;
    send(ctl, dat);
    @(negedge clk);
    check("quad_sio_e", spi_sio_e, 4'hF);
    check("quad_bit0", spi_sio_o, 4'b1010);
    repeat (2) @(negedge clk);
    check("quad_bit1", spi_sio_o, 4'b0001);
    repeat (2) @(negedge clk);
    check("quad_no_qin", qin_vld, 0);
    check("quad_idle_sio_e", spi_sio_e, 4'h0);
    check("quad_sio_o_hold", spi_sio_o, 4'b0001);
    wait_idle();

    // Backpressure on the captured word
    lb_mode = 2'd1;
    @(posedge clk);
    #1;
    qin_rdy = 1'b0;
    ctl = mk_ctl(3'd3, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    dat = 32'h0000_00C0;
    push_exp(ctl, dat);
    send(ctl, dat);
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (qin_vld) break;
    end
    check("bp_vld", qin_vld, 1);
    ctl2 = mk_ctl(3'd7, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    dat2 = 32'h0000_0096;
    que_ctl = ctl2;
    que_dat = dat2;
    que_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_que_rdy_low", que_rdy, 0);
      check("bp_dat_hold", qin_dat, cap_model(2'd1, 3'd3, dat));
      check("bp_ctl_hold", qin_ctl, {3'd3, 1'b0, 2'd1});
    end
    @(posedge clk);
    #1;
    qin_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_accept_rdy", que_rdy, 1);
    push_exp(ctl2, dat2);
    @(posedge clk);
    #1;
    que_vld = 1'b0;
    @(negedge clk);
    check("bp_started", que_rdy, 0);
    check("bp_started_sio_e", spi_sio_e, 4'b0001);
    wait_idle();

    // Dummy cycles: SCLK held, data still shifts every bit time
    lb_mode  = 2'd0;
    cfg_div  = 8'd3;
    cfg_cpol = 1'b1;
    ctl = mk_ctl(3'd7, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    dat = 32'h0000_003C;
    send(ctl, dat);
    bad      = 0;
    bad_ss   = 0;
    bad_mosi = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (spi_sclk !== 1'b1) bad++;
      if (spi_ss_n !== 1'b0) bad_ss++;
      if (spi_sio_o[0] !== dat[7 - i/8]) bad_mosi++;
    end
    check("cke0_sclk_const", bad, 0);
    check("cke0_ss_n_low", bad_ss, 0);
    check("cke0_mosi", bad_mosi, 0);
    @(negedge clk);
    check("cke0_ss_n_hold", spi_ss_n, 0);
    check("cke0_no_qin", qin_vld, 0);
    wait_idle();

    // Single-bit dual packet with CPOL=1
    lb_mode  = 2'd2;
    cfg_div  = 8'd1;
    cfg_cpol = 1'b1;
    ctl = mk_ctl(3'd0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    dat = 32'h0000_807F;
    push_exp(ctl, dat);
    send(ctl, dat);
    sclk_seq = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) check("dual_sio_e", spi_sio_e, 4'b0011);
      sclk_seq = {sclk_seq[2:0], spi_sclk};
    end
    check("dual_sclk_pulse", sclk_seq, 4'b1100);
    @(negedge clk);
    check("dual_idle_sclk", spi_sclk, 1);
    check("dual_vld", qin_vld, 1);
    check("dual_dat", qin_dat, 32'h0000_0100);
    wait_idle();

    // Random loopback packets through the scoreboard
    for (int n = 0; n < 8; n++) begin
      iom      = 2'($urandom_range(0, 3));
      len      = 3'($urandom_range(0, 7));
      cfg_div  = 8'($urandom_range(0, 2));
      cfg_cpol = 1'($urandom_range(0, 1));
      lb_mode  = (iom == 2'd1) ? 2'd1 : 2'd2;
      dat      = $urandom;
      ctl = mk_ctl(len, 1'($urandom_range(0, 1)), iom, 1'b1, 1'b1, 1'b1,
                   1'($urandom_range(0, 1)));
      push_exp(ctl, dat);
      send(ctl, dat);
      wait_idle();
    end

    // Reset in the middle of a packet
    cfg_div  = 8'd0;
    cfg_cpol = 1'b0;
    lb_mode  = 2'd1;
    ctl = mk_ctl(3'd7, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    dat = 32'h0000_005A;
    send(ctl, dat);
    repeat (8) @(negedge clk);
    check("mid_sclk_high", spi_sclk, 1);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ss_n", spi_ss_n, 1);
    check("abort_sio_e", spi_sio_e, 4'h0);
    check("abort_sclk", spi_sclk, 0);
    check("abort_qin_vld", qin_vld, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_abort_qin", qin_vld, 0);
      check("post_abort_rdy", que_rdy, 1);
    end
    dat = 32'h0000_00E1;
    push_exp(ctl, dat);
    send(ctl, dat);
    @(negedge clk);
    check("restart_ss_n", spi_ss_n, 0);
    wait_idle();

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
